// File: rtl/vc_arbiter.sv
// vc_arbiter: two-VC to two-destination arbiter.
// VC0 has default priority. After MAX_STREAK consecutive VC0 grants while
// VC1 is waiting, VC1 is granted once. Pops are combinational from the
// current inputs and registered state. The popped word is registered into
// data_out and pushed to D0 or D1 one cycle later. Bit BITNUMBER-2 of the
// word selects the destination.
// Ports:
//   clk, reset (async active-low)
//   vc0_empty/vc1_empty, vc0_data/vc1_data : show-ahead source FIFO heads
//   d0_almost_full/d1_almost_full          : destination back-pressure
//   vc0_pop/vc1_pop                        : source pops (combinational)
//   data_out, d0_push/d1_push              : registered forwarded word and pushes
//   grant_state                            : registered FSM state
//   vc0_count/vc1_count                    : forwarded-word counters (wrap at 256)
module vc_arbiter #(
  parameter int BITNUMBER  = 6,
  parameter int MAX_STREAK = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 vc0_empty,
  input  logic                 vc1_empty,
  input  logic [BITNUMBER-1:0] vc0_data,
  input  logic [BITNUMBER-1:0] vc1_data,
  input  logic                 d0_almost_full,
  input  logic                 d1_almost_full,
  output logic                 vc0_pop,
  output logic                 vc1_pop,
  output logic [BITNUMBER-1:0] data_out,
  output logic                 d0_push,
  output logic                 d1_push,
  output logic [1:0]           grant_state,
  output logic [7:0]           vc0_count,
  output logic [7:0]           vc1_count
);

  localparam int SW = $clog2(MAX_STREAK) + 1;
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_STREAK);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SERV0 = 2'b01,
    SERV1 = 2'b10,
    HOLD  = 2'b11
  } state_t;

  state_t               state_r;
  state_t               state_s;
  logic [SW-1:0]        streak_r;
  logic                 pause_s;
  logic                 streak_full_s;
  logic                 vc0_pop_s;
  logic                 vc1_pop_s;
  logic [BITNUMBER-1:0] popped_word_s;
  logic [BITNUMBER-1:0] data_out_r;
  logic                 d0_push_r;
  logic                 d1_push_r;
  logic [7:0]           vc0_count_r;
  logic [7:0]           vc1_count_r;

  // Pop arbitration and next-state decode.
  always_comb begin
    vc0_pop_s     = 1'b0;
    vc1_pop_s     = 1'b0;
    state_s       = IDLE;
    pause_s       = d0_almost_full | d1_almost_full;
    // VC1 has waited long enough: it overrides VC0 this cycle.
    streak_full_s = (streak_r == STREAK_MAX) && !vc1_empty;

    // Pops are gated by reset so they drop immediately, without waiting for a clock edge.
    if (reset && !pause_s) begin
      if (!vc0_empty && !streak_full_s) begin
        vc0_pop_s = 1'b1;
      end else if (!vc1_empty) begin
        vc1_pop_s = 1'b1;
      end else begin
        vc0_pop_s = 1'b0;
        vc1_pop_s = 1'b0;
      end
    end else begin
      vc0_pop_s = 1'b0;
      vc1_pop_s = 1'b0;
    end

    if (vc0_pop_s) begin
      state_s = SERV0;
    end else if (vc1_pop_s) begin
      state_s = SERV1;
    end else if (pause_s && (!vc0_empty || !vc1_empty)) begin
      state_s = HOLD;
    end else begin
      state_s = IDLE;
    end

    popped_word_s = vc0_pop_s ? vc0_data : vc1_data;
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Streak tracking: counts VC0 grants only while VC1 has data waiting.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      streak_r <= {SW{1'b0}};
    end else if (vc1_pop_s || vc1_empty) begin
      streak_r <= {SW{1'b0}};
    end else if (vc0_pop_s) begin
      streak_r <= streak_r + SW'(1);
    end else begin
      streak_r <= streak_r;
    end
  end

  // Output word capture and destination push (one-cycle latency).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data_out_r <= {BITNUMBER{1'b0}};
      d0_push_r  <= 1'b0;
      d1_push_r  <= 1'b0;
    end else if (vc0_pop_s || vc1_pop_s) begin
      data_out_r <= popped_word_s;
      d0_push_r  <= ~popped_word_s[BITNUMBER-2];
      d1_push_r  <= popped_word_s[BITNUMBER-2];
    end else begin
      data_out_r <= data_out_r;
      d0_push_r  <= 1'b0;
      d1_push_r  <= 1'b0;
    end
  end

  // Forwarded-word counters, naturally wrapping at 8 bits.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vc0_count_r <= 8'd0;
      vc1_count_r <= 8'd0;
    end else begin
      vc0_count_r <= vc0_pop_s ? (vc0_count_r + 8'd1) : vc0_count_r;
      vc1_count_r <= vc1_pop_s ? (vc1_count_r + 8'd1) : vc1_count_r;
    end
  end

  assign vc0_pop     = vc0_pop_s;
  assign vc1_pop     = vc1_pop_s;
  assign data_out    = data_out_r;
  assign d0_push     = d0_push_r;
  assign d1_push     = d1_push_r;
  assign grant_state = state_r;
  assign vc0_count   = vc0_count_r;
  assign vc1_count   = vc1_count_r;

endmodule
